// File: rtl/pwm_generator_pkg.sv
// Shared configuration for the PWM generator slice.
//   DEFAULT_N_BITS : default width of the duty word and of the period counter.
//                    The PWM period is 2**N_bits clock cycles.
package pwm_generator_pkg;

  localparam int DEFAULT_N_BITS = 8;

endpackage : pwm_generator_pkg

// File: rtl/pwm_generator_if.sv
// Duty-in / PWM-out bundle of the PWM generator.
//   duty    : duty-cycle word, unsigned, 0 .. 2**N_bits-1 (driven by the sample path)
//   PWM_out : registered PWM output (driven by the generator)
// Modports:
//   master : the upstream duty source, which also observes PWM_out
//   slave  : the PWM generator
interface pwm_generator_if
  import pwm_generator_pkg::*;
#(
  parameter int N_bits = DEFAULT_N_BITS
);

  logic [N_bits-1:0] duty;
  logic              PWM_out;

  modport master (output duty, input  PWM_out);
  modport slave  (input  duty, output PWM_out);

endinterface : pwm_generator_if

// File: rtl/pwm_counter.sv
// Free-running period counter of the PWM generator.
//   clk : system clock, counts on the rising edge
//   rst : asynchronous, active-low reset; forces cnt to 0 at once
//   cnt : current position within the PWM period, 0 .. 2**N_bits-1
// The counter wraps from all-ones to zero with no idle cycle, so every
// period is exactly 2**N_bits cycles long.
module pwm_counter
  import pwm_generator_pkg::*;
#(
  parameter int N_bits = DEFAULT_N_BITS
) (
  input  logic              clk,
  input  logic              rst,
  output logic [N_bits-1:0] cnt
);

  // NOTE: rst sits in the sensitivity list so the clear happens the moment
  // rst falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      // NOTE: non-blocking assignment for every flop, so all registers sample
      // their inputs from the same (pre-edge) values.
      cnt <= cnt + N_bits'(1);   // natural modulo-2**N_bits wrap
    end
  end

endmodule : pwm_counter

// File: rtl/pwm_generator.sv
// Single-channel pulse-width modulator.
//   clk : system clock; all state changes on the rising edge
//   rst : asynchronous, active-low reset; counter and PWM_out cleared at once
//   bus : pwm_generator_if.slave
//           duty    (in)  duty-cycle word, sampled every cycle
//           PWM_out (out) registered output, high for 'duty' of every
//                         2**N_bits cycles
// The comparison uses the counter value before its increment, so after reset
// release the k-th rising edge yields (k mod 2**N_bits) < duty. duty has no
// shadow register: a change is seen at the very next edge, even mid-period,
// so glitch-free periods rely on the source updating duty at cnt = 0.
// duty = 0 gives a constant low; 100 % duty is not reachable (all-ones duty
// still leaves one low cycle per period).
module pwm_generator
  import pwm_generator_pkg::*;
#(
  parameter int N_bits = DEFAULT_N_BITS
) (
  input  logic            clk,
  input  logic            rst,
  pwm_generator_if.slave  bus
);

  logic [N_bits-1:0] cnt;

  pwm_counter #(
    .N_bits (N_bits)
  ) u_counter (
    .clk (clk),
    .rst (rst),
    .cnt (cnt)
  );

  // Unsigned N_bits-wide compare against the live duty word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.PWM_out <= 1'b0;
    end else begin
      bus.PWM_out <= (cnt < bus.duty);
    end
  end

endmodule : pwm_generator

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator.
// Stimulus issues one duty/reset value per clock (at the falling edge) and
// pushes the hand-computed PWM_out expected after the following rising edge.
// A monitor per DUT pops one expectation per rising edge and compares.
module tb_pwm_generator;

  logic clk;
  logic rst;
  logic rst4;

  int   total;
  int   bad;
  string phase;

  bit   q8 [$];
  bit   q4 [$];

  pwm_generator_if #(.N_bits(8)) bus8 ();
  pwm_generator_if #(.N_bits(4)) bus4 ();

  pwm_generator #(.N_bits(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  pwm_generator #(.N_bits(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus for the 8-bit DUT: set rst/duty before the
  // rising edge and record what PWM_out must be after it.
  task automatic step8(input logic r, input logic [7:0] d, input bit e);
    @(negedge clk);
    rst       = r;
    bus8.duty = d;
    q8.push_back(e);
  endtask

  task automatic step4(input logic r, input logic [3:0] d, input bit e);
    @(negedge clk);
    rst4      = r;
    bus4.duty = d;
    q4.push_back(e);
  endtask

  // Monitors: sample 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (q8.size() > 0) begin
      bit e;
      e = q8.pop_front();
      check({"pwm8_", phase}, {31'b0, bus8.PWM_out}, {31'b0, e});
    end
  end

  always @(posedge clk) begin
    #1;
    if (q4.size() > 0) begin
      bit e;
      e = q4.pop_front();
      check("pwm4_duty5", {31'b0, bus4.PWM_out}, {31'b0, e});
    end
  end

  // Watchdog: the clock always runs, so only a stuck stimulus could hang.
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    total     = 0;
    bad       = 0;
    phase     = "reset";
    bus8.duty = '0;
    bus4.duty = '0;
    rst       = 1'b1;
    rst4      = 1'b1;
    #1;
    rst       = 1'b0;   // falling edge: asynchronous clear of both DUTs
    rst4      = 1'b0;
    #1;
    check("reset_pwm8_at_once", {31'b0, bus8.PWM_out}, 32'd0);
    check("reset_pwm4_at_once", {31'b0, bus4.PWM_out}, 32'd0);

    // Reset held while clocking, even with a nonzero duty applied.
    for (int j = 0; j < 4; j++) step8(1'b0, 8'd200, 1'b0);

    // Exhaustive sweep: duty i applied at each period start, released from
    // reset so the first period starts at edge 0.
    phase = "sweep";
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++)
        step8(1'b1, 8'(i), j < i);

    // duty = 0 over three periods: never high.
    phase = "duty0";
    for (int j = 0; j < 768; j++) step8(1'b1, 8'd0, 1'b0);

    // duty = 255: 255 high edges, one low edge at cnt = 255, wrap straight on.
    phase = "duty255";
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < 256; j++)
        step8(1'b1, 8'd255, j != 255);

    // Mid-period change: 200 for edges 0..49, then 10. Edges 50.. are low
    // until the wrap; the next period is high for 10 edges.
    phase = "midchange";
    for (int j = 0; j < 50; j++)   step8(1'b1, 8'd200, 1'b1);
    for (int j = 50; j < 256; j++) step8(1'b1, 8'd10,  1'b0);
    for (int j = 0; j < 256; j++)  step8(1'b1, 8'd10,  j < 10);

    // Reset asserted mid-period while PWM_out is high (duty = 128, edge 39).
    phase = "prereset";
    for (int j = 0; j < 40; j++) step8(1'b1, 8'd128, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("reset_mid_period_at_once", {31'b0, bus8.PWM_out}, 32'd0);
    phase = "held_reset";
    for (int j = 0; j < 3; j++) step8(1'b0, 8'd128, 1'b0);
    // First edge after release starts a new period: high at once.
    phase = "after_reset";
    for (int j = 0; j < 256; j++) step8(1'b1, 8'd128, j < 128);

    // N_bits = 4: period 16, duty 5 -> 5 high / 11 low, four periods.
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 16; j++)
        step4(1'b1, 4'd5, j < 5);

    @(posedge clk);
    #2;
    check("queue8_drained", q8.size(), 32'd0);
    check("queue4_drained", q4.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pwm_generator
